// File: rtl/tile_dispatcher.sv
// tile_dispatcher: hands out the tiles of a mu x mu job in row-major order to
// NUM_PROC processors using an offer/ack handshake, tracks which processors are
// busy, and counts completed tiles until the whole job is finished.
// Optional feature macro: TILE_DISPATCHER_CYCLE_COUNT_EN adds out_cycles, a
// 32-bit saturating count of the cycles for which out_busy was high.
module tile_dispatcher #(
    parameter int NUM_PROC    = 4,
    parameter int index_width = 8
) (
    input  logic                   in_clk,
    input  logic                   in_reset,
    input  logic                   in_start,
    input  logic [index_width-1:0] in_blocks,
    input  logic [NUM_PROC-1:0]    in_index_ack,
    input  logic [NUM_PROC-1:0]    in_result_ready,
    output logic [index_width-1:0] out_row_index,
    output logic [index_width-1:0] out_col_index,
    output logic [index_width-1:0] out_mu,
    output logic [NUM_PROC-1:0]    out_index_ready,
    output logic                   out_busy,
    output logic                   out_done
`ifdef TILE_DISPATCHER_CYCLE_COUNT_EN
    ,
    output logic [31:0]            out_cycles
`endif
);

    localparam int CW = 2 * index_width;
    localparam logic [index_width-1:0] ONE_IDX = {{(index_width-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, DISPATCH, WAIT_ACK, DRAIN, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [index_width-1:0] mu_reg, mu_next;
    logic [index_width-1:0] i_reg, i_next;
    logic [index_width-1:0] j_reg, j_next;
    logic [NUM_PROC-1:0]    ready_reg, ready_next;
    logic [NUM_PROC-1:0]    busy_reg, busy_next;
    logic                   busy_flag_reg, busy_flag_next;
    logic                   done_reg, done_next;
    logic [CW-1:0]          completed_reg, completed_next;

    logic [NUM_PROC-1:0]    result_hit;
    logic [NUM_PROC-1:0]    sel_onehot;
    logic [CW-1:0]          result_cnt;
    logic [index_width-1:0] mu_last;
    logic [CW-1:0]          mu_wide;
    logic [CW-1:0]          mu_sq;
    logic                   any_idle;

    // A result only counts when it comes from a processor that holds a tile
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PROC; gi++) begin : g_hit
            assign result_hit[gi] = in_result_ready[gi] & busy_reg[gi];
        end
    endgenerate

    assign mu_last  = mu_reg - ONE_IDX;
    assign mu_wide  = {{index_width{1'b0}}, mu_reg};
    assign mu_sq    = mu_wide * mu_wide;
    assign any_idle = ~(&busy_reg);

    // Lowest-numbered idle processor and number of accepted results this cycle
    always_comb begin
        sel_onehot = '0;
        result_cnt = '0;
        for (int k = NUM_PROC - 1; k >= 0; k--) begin
            if (!busy_reg[k]) begin
                sel_onehot    = '0;
                sel_onehot[k] = 1'b1;
            end
        end
        for (int k = 0; k < NUM_PROC; k++) begin
            result_cnt = result_cnt + {{(CW-1){1'b0}}, result_hit[k]};
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_next     = state_reg;
        mu_next        = mu_reg;
        i_next         = i_reg;
        j_next         = j_reg;
        ready_next     = ready_reg;
        busy_flag_next = busy_flag_reg;
        done_next      = 1'b0;
        completed_next = completed_reg + result_cnt;
        busy_next      = busy_reg & ~result_hit;
        case (state_reg)
            IDLE: begin
                if (in_start) begin
                    mu_next        = in_blocks;
                    i_next         = '0;
                    j_next         = '0;
                    completed_next = '0;
                    busy_next      = '0;
                    busy_flag_next = 1'b1;
                    state_next     = (in_blocks == '0) ? DONE : DISPATCH;
                end
            end
            DISPATCH: begin
                if (any_idle) begin
                    ready_next = sel_onehot;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (|(in_index_ack & ready_reg)) begin
                    busy_next  = busy_next | ready_reg;
                    ready_next = '0;
                    state_next = DISPATCH;
                    if (j_reg == mu_last) begin
                        if (i_reg == mu_last) begin
                            // Last tile: keep the indices where they are
                            state_next = DRAIN;
                        end else begin
                            j_next = '0;
                            i_next = i_reg + ONE_IDX;
                        end
                    end else begin
                        j_next = j_reg + ONE_IDX;
                    end
                end
            end
            DRAIN: begin
                if ((busy_reg == '0) && (completed_reg == mu_sq)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_next      = 1'b1;
                busy_flag_next = 1'b0;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; reset abandons any job in flight
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            state_reg     <= IDLE;
            mu_reg        <= '0;
            i_reg         <= '0;
            j_reg         <= '0;
            ready_reg     <= '0;
            busy_reg      <= '0;
            busy_flag_reg <= 1'b0;
            done_reg      <= 1'b0;
            completed_reg <= '0;
        end else begin
            state_reg     <= state_next;
            mu_reg        <= mu_next;
            i_reg         <= i_next;
            j_reg         <= j_next;
            ready_reg     <= ready_next;
            busy_reg      <= busy_next;
            busy_flag_reg <= busy_flag_next;
            done_reg      <= done_next;
            completed_reg <= completed_next;
        end
    end

    assign out_row_index   = i_reg;
    assign out_col_index   = j_reg;
    assign out_mu          = mu_reg;
    assign out_index_ready = ready_reg;
    assign out_busy        = busy_flag_reg;
    assign out_done        = done_reg;

`ifdef TILE_DISPATCHER_CYCLE_COUNT_EN
    logic [31:0] cycles_reg;

    // Saturating busy-cycle counter, cleared when a job is accepted
    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            cycles_reg <= '0;
        end else if ((state_reg == IDLE) && in_start) begin
            cycles_reg <= '0;
        end else if (busy_flag_reg && (cycles_reg != 32'hFFFF_FFFF)) begin
            cycles_reg <= cycles_reg + 32'd1;
        end
    end

    assign out_cycles = cycles_reg;
`endif

endmodule

// File: tb/tb_tile_dispatcher.sv
// Scoreboard bench for tile_dispatcher: stimulus pushes the expected offers
// and done pulses into a queue, a monitor pops and compares them as the DUT
// presents them, and a processor model acks offers and returns results.
module tb_tile_dispatcher;

    localparam int NP = 4;

    typedef struct packed {
        logic       kind;   // 0 = offer, 1 = done
        logic [3:0] mask;
        logic [7:0] row;
        logic [7:0] col;
    } exp_t;

    logic        in_clk = 1'b0;
    logic        in_reset = 1'b1;
    logic        in_start = 1'b0;
    logic [7:0]  in_blocks = 8'd0;
    logic [3:0]  in_index_ack = 4'd0;
    logic [3:0]  in_result_ready = 4'd0;
    logic [7:0]  out_row_index, out_col_index, out_mu;
    logic [3:0]  out_index_ready;
    logic        out_busy, out_done;
`ifdef TILE_DISPATCHER_CYCLE_COUNT_EN
    logic [31:0] out_cycles;
`endif

    tile_dispatcher #(.NUM_PROC(NP), .index_width(8)) dut (
        .in_clk(in_clk),
        .in_reset(in_reset),
        .in_start(in_start),
        .in_blocks(in_blocks),
        .in_index_ack(in_index_ack),
        .in_result_ready(in_result_ready),
        .out_row_index(out_row_index),
        .out_col_index(out_col_index),
        .out_mu(out_mu),
        .out_index_ready(out_index_ready),
        .out_busy(out_busy),
        .out_done(out_done)
`ifdef TILE_DISPATCHER_CYCLE_COUNT_EN
        ,
        .out_cycles(out_cycles)
`endif
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   offers_seen = 0;
    int   done_cnt = 0;
    int   acks_sent = 0;
    int   results_sent = 0;
    int   results_at_done = 0;
    int   res_delay = 10;
    bit   auto_ack = 1'b1;
    logic [3:0] force_ack = 4'd0;
    int   res_cnt[NP] = '{-1, -1, -1, -1};

    initial forever #5 in_clk = ~in_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_offer(input logic [3:0] m, input logic [7:0] r, input logic [7:0] c);
        exp_t e;
        e.kind = 1'b0; e.mask = m; e.row = r; e.col = c;
        exp_q.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e = '0;
        e.kind = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge in_clk);
            #1;
        end
    endtask

    task automatic start_job(input logic [7:0] mu);
        tick(1);
        in_blocks = mu;
        in_start  = 1'b1;
        tick(1);
        in_start  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < limit) begin
            tick(1);
            n++;
        end
        chk(name, 64'(done_cnt != base), 64'd1);
    endtask

    // Processor model: clears pulses, runs result timers, acks offers
    initial begin
        forever begin
            @(negedge in_clk);
            in_index_ack    = 4'd0;
            in_result_ready = 4'd0;
            if (in_reset) begin
                for (int p = 0; p < NP; p++) res_cnt[p] = -1;
            end else begin
                for (int p = 0; p < NP; p++) begin
                    if (res_cnt[p] > 0) begin
                        res_cnt[p]--;
                        if (res_cnt[p] == 0) begin
                            in_result_ready[p] = 1'b1;
                            res_cnt[p] = -1;
                            results_sent++;
                        end
                    end
                end
                in_index_ack = force_ack | (auto_ack ? out_index_ready : 4'd0);
                for (int p = 0; p < NP; p++) begin
                    if (in_index_ack[p] && out_index_ready[p]) begin
                        res_cnt[p] = res_delay;
                        acks_sent++;
                    end
                end
            end
        end
    end

    // Monitor: pops one expectation per new offer or done pulse
    initial begin
        logic [3:0] prev_ready;
        exp_t e;
        prev_ready = 4'd0;
        forever begin
            @(negedge in_clk);
            if (out_index_ready != 4'd0 && prev_ready == 4'd0) begin
                offers_seen++;
                $display("offer mask=%b row=%0d col=%0d", out_index_ready, out_row_index, out_col_index);
                if (exp_q.size() == 0) begin
                    chk("unexpected_offer", 64'(out_index_ready), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("offer", 64'({1'b0, out_index_ready, out_row_index, out_col_index}), 64'(e));
                end
            end
            if (out_done) begin
                done_cnt++;
                results_at_done = results_sent;
                $display("done pulse mu=%0d", out_mu);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_order", 64'(e.kind), 64'd1);
                end
            end
            prev_ready = out_index_ready;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(out_index_ready), 64'd0);
        chk({tag, "_busy"},  64'(out_busy), 64'd0);
        chk({tag, "_done"},  64'(out_done), 64'd0);
        chk({tag, "_row"},   64'(out_row_index), 64'd0);
        chk({tag, "_col"},   64'(out_col_index), 64'd0);
        chk({tag, "_mu"},    64'(out_mu), 64'd0);
    endtask

    initial begin
        int abase, rbase, obase, bad, n;

        // Reset state
        #2;
        chk_all_zero("reset");
        tick(3);
        in_reset = 1'b0;
        tick(2);

        // Test 1: mu=2, immediate acks, results after 10 cycles
        auto_ack = 1'b1; res_delay = 10;
        push_offer(4'b0001, 8'd0, 8'd0);
        push_offer(4'b0010, 8'd0, 8'd1);
        push_offer(4'b0100, 8'd1, 8'd0);
        push_offer(4'b1000, 8'd1, 8'd1);
        push_done();
        n = done_cnt;
        start_job(8'd2);
        chk("t1_busy_rise", 64'(out_busy), 64'd1);
        chk("t1_mu", 64'(out_mu), 64'd2);
        wait_done("t1_done_seen", 200);
        tick(5);
        chk("t1_done_once", 64'(done_cnt - n), 64'd1);
        chk("t1_busy_drop", 64'(out_busy), 64'd0);
        chk("t1_q_empty", 64'(exp_q.size()), 64'd0);

        // Test 2: mu=3, results delayed 30 cycles
        res_delay = 30;
        abase = acks_sent; rbase = results_sent; obase = offers_seen;
        push_offer(4'b0001, 8'd0, 8'd0);
        push_offer(4'b0010, 8'd0, 8'd1);
        push_offer(4'b0100, 8'd0, 8'd2);
        push_offer(4'b1000, 8'd1, 8'd0);
        push_offer(4'b0001, 8'd1, 8'd1);
        push_offer(4'b0010, 8'd1, 8'd2);
        push_offer(4'b0100, 8'd2, 8'd0);
        push_offer(4'b1000, 8'd2, 8'd1);
        push_offer(4'b0001, 8'd2, 8'd2);
        push_done();
        start_job(8'd3);
        n = 0;
        while (offers_seen < obase + 4 && n < 50) begin tick(1); n++; end
        chk("t2_four_offers", 64'(offers_seen - obase), 64'd4);
        bad = 0; n = 0;
        while (results_sent == rbase && n < 100) begin
            tick(1);
            n++;
            if (out_index_ready != 4'd0 && results_sent == rbase) bad++;
        end
        chk("t2_stall_no_offer", 64'(bad), 64'd0);
        chk("t2_stall_long", 64'(n >= 20), 64'd1);
        wait_done("t2_done_seen", 400);
        chk("t2_acks", 64'(acks_sent - abase), 64'd9);
        chk("t2_results_at_done", 64'(results_at_done - rbase), 64'd9);
        chk("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // Test 3: mu=0 goes straight to done two cycles after start
        obase = offers_seen;
        push_done();
        start_job(8'd0);
        chk("t3_done_early", 64'(out_done), 64'd0);
        tick(1);
        chk("t3_done_pulse", 64'(out_done), 64'd1);
        tick(1);
        chk("t3_done_single", 64'(out_done), 64'd0);
        chk("t3_no_offers", 64'(offers_seen - obase), 64'd0);
        chk("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // Test 4: ack withheld 20 cycles, spurious acks elsewhere ignored
        auto_ack = 1'b0; res_delay = 5;
        push_offer(4'b0001, 8'd0, 8'd0);
        push_offer(4'b0010, 8'd0, 8'd1);
        push_offer(4'b0001, 8'd1, 8'd0);
        push_offer(4'b0100, 8'd1, 8'd1);
        push_done();
        start_job(8'd2);
        n = 0;
        while (out_index_ready == 4'd0 && n < 20) begin tick(1); n++; end
        force_ack = 4'b0001;
        tick(1);
        force_ack = 4'd0;
        n = 0;
        while (out_index_ready != 4'b0010 && n < 20) begin tick(1); n++; end
        chk("t4_second_offer", 64'(out_index_ready), 64'b0010);
        for (int c = 0; c < 20; c++) begin
            if (c == 5) force_ack = 4'b0101;
            if (c == 6) force_ack = 4'd0;
            tick(1);
            chk("t4_hold", 64'({out_index_ready, out_row_index, out_col_index}),
                64'({4'b0010, 8'd0, 8'd1}));
        end
        force_ack = 4'b0010;
        auto_ack = 1'b1;
        tick(1);
        force_ack = 4'd0;
        wait_done("t4_done_seen", 200);
        chk("t4_q_empty", 64'(exp_q.size()), 64'd0);

        // Test 5: reset mid-job with two processors busy, then mu=1
        res_delay = 50;
        abase = acks_sent;
        push_offer(4'b0001, 8'd0, 8'd0);
        push_offer(4'b0010, 8'd0, 8'd1);
        start_job(8'd2);
        n = 0;
        while (acks_sent < abase + 2 && n < 50) begin tick(1); n++; end
        chk("t5_two_busy", 64'(acks_sent - abase), 64'd2);
        in_reset = 1'b1;
        #2;
        chk_all_zero("t5_async");
        exp_q.delete();
        tick(2);
        in_reset = 1'b0;
        tick(4);
        chk("t5_no_resume_busy", 64'(out_busy), 64'd0);
        chk("t5_no_resume_ready", 64'(out_index_ready), 64'd0);
        res_delay = 3;
        push_offer(4'b0001, 8'd0, 8'd0);
        push_done();
        start_job(8'd1);
        wait_done("t5_done_seen", 100);
        chk("t5_q_empty", 64'(exp_q.size()), 64'd0);

`ifdef TILE_DISPATCHER_CYCLE_COUNT_EN
        // Test 6: mu=1, ack sampled 2 edges after start, result 5 edges later
        res_delay = 5;
        push_offer(4'b0001, 8'd0, 8'd0);
        push_done();
        start_job(8'd1);
        wait_done("t6_done_seen", 100);
        tick(2);
        chk("t6_cycles", 64'(out_cycles), 64'd9);
        tick(10);
        chk("t6_cycles_hold", 64'(out_cycles), 64'd9);
`endif

        tick(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
